// File: rtl/uop_seq.sv
// uop_seq: micro-op sequencer between decode and execute.
// Issues one uop per cycle, either directly from the decoder or from a
// synchronous microcode ROM, and forces a fault on sequence overrun.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   decValid/decUopPc/    decoder instruction: ROM entry (0 = direct),
//   decUopWord/decStepPc  direct uop word and PC step
//   exHold, exFlush       execute stall and abandon
//   romAddr, romData      ROM address (comb) and registered data
//   exUopWord/exValid/    registered uop bundle to execute
//   exPcStep
//   ifHold                fetch/decode stall while sequencing
//   seqFault              overrun pulse with the forced final uop
module uop_seq #(
  parameter int unsigned MAX_UOPS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        decValid,
  input  logic [11:0] decUopPc,
  input  logic [31:0] decUopWord,
  input  logic [1:0]  decStepPc,
  input  logic        exHold,
  input  logic        exFlush,
  output logic [11:0] romAddr,
  input  logic [31:0] romData,
  output logic [31:0] exUopWord,
  output logic        exValid,
  output logic [1:0]  exPcStep,
  output logic        ifHold,
  output logic        seqFault
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] CNT_LAST =
    4'(MAX_UOPS - 1);

  state_e      state_q;
  logic [11:0] upc_q;
  logic [3:0]  cnt_q;
  logic [1:0]  saved_step_q;
  logic [31:0] word_q;
  logic        valid_q;
  logic [1:0]  pc_step_q;
  logic        fault_q;

  logic [11:0] upc_d;
  logic [3:0]  cnt_d;
  logic        end_bit;
  logic        final_uop;
  logic        advance;

  assign end_bit = romData[23];

  // A uop is final on its END bit, or when the
  // count or address would run past its limit.
  assign final_uop = end_bit
                   | (cnt_q == CNT_LAST)
                   | (upc_q == 12'hFFF);

  assign advance = (state_q == RUN)
                 & ~exHold
                 & ~exFlush
                 & ~final_uop;

  assign upc_d = upc_q + 12'd1;
  assign cnt_d = cnt_q + 4'd1;

  // The ROM is one cycle behind: point it at the
  // uop we will need on the next cycle.
  always_comb begin
    romAddr = upc_q;
    if (state_q == IDLE) begin
      romAddr = decUopPc;
    end else if (advance) begin
      romAddr = upc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      upc_q        <= '0;
      cnt_q        <= '0;
      saved_step_q <= '0;
      word_q       <= '0;
      valid_q      <= 1'b0;
      pc_step_q    <= '0;
      fault_q      <= 1'b0;
    end else if (exFlush) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      pc_step_q <= '0;
      fault_q   <= 1'b0;
    end else if (!exHold) begin
      unique case (state_q)
        IDLE: begin
          valid_q   <= 1'b0;
          pc_step_q <= '0;
          fault_q   <= 1'b0;
          if (decValid) begin
            if (decUopPc == 12'd0) begin
              word_q    <= decUopWord;
              valid_q   <= 1'b1;
              pc_step_q <= decStepPc;
            end else begin
              upc_q        <= decUopPc;
              cnt_q        <= '0;
              saved_step_q <= decStepPc;
              state_q      <= RUN;
            end
          end
        end
        RUN: begin
          word_q  <= romData;
          valid_q <= 1'b1;
          if (final_uop) begin
            pc_step_q <= saved_step_q;
            fault_q   <= ~end_bit;
            state_q   <= IDLE;
          end else begin
            pc_step_q <= '0;
            fault_q   <= 1'b0;
            upc_q     <= upc_d;
            cnt_q     <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign exUopWord = word_q;
  assign exValid   = valid_q;
  assign exPcStep  = pc_step_q;
  assign seqFault  = fault_q;
  assign ifHold    = (state_q == RUN);

endmodule

// File: tb/tb_uop_seq.sv
// tb_uop_seq: directed self-checking bench for uop_seq.
// Models the synchronous ROM; expected values are hand-derived.
module tb_uop_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        decValid;
  logic [11:0] decUopPc;
  logic [31:0] decUopWord;
  logic [1:0]  decStepPc;
  logic        exHold;
  logic        exFlush;
  logic [11:0] romAddr;
  logic [31:0] romData;
  logic [31:0] exUopWord;
  logic        exValid;
  logic [1:0]  exPcStep;
  logic        ifHold;
  logic        seqFault;

  logic [31:0] rom [4096];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) romData <= rom[romAddr];

  uop_seq #(.MAX_UOPS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .decValid   (decValid),
    .decUopPc   (decUopPc),
    .decUopWord (decUopWord),
    .decStepPc  (decStepPc),
    .exHold     (exHold),
    .exFlush    (exFlush),
    .romAddr    (romAddr),
    .romData    (romData),
    .exUopWord  (exUopWord),
    .exValid    (exValid),
    .exPcStep   (exPcStep),
    .ifHold     (ifHold),
    .seqFault   (seqFault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    decValid   = 1'b0;
    decUopPc   = '0;
    decUopWord = '0;
    decStepPc  = '0;
    exHold     = 1'b0;
    exFlush    = 1'b0;
  endtask

  // Outputs packed as {valid, step, word, ifHold, fault}.
  task automatic test_reset();
    logic [36:0] got;
    quiet();
    reset = 1'b1;
    step();
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== 37'd0) begin
      n_fails++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [36:0] got;
    decValid   = 1'b1;
    decUopPc   = 12'd0;
    decUopWord = 32'h1F80_0000;
    decStepPc  = 2'd1;
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd1, 32'h1F80_0000, 2'b00}) begin
      n_fails++;
      $display("FAIL single got=%h", got);
    end
    quiet();
    step();
    n_checks++;
    if ({exValid, exPcStep} !== 3'b000) begin
      n_fails++;
      $display("FAIL single_idle got=%b exp=000",
               {exValid, exPcStep});
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] got;
    decValid   = 1'b1;
    decUopWord = 32'h1111_0001;
    decStepPc  = 2'd1;
    step();
    decUopWord = 32'h2222_0002;
    decStepPc  = 2'd2;
    exHold     = 1'b1;
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd1, 32'h1111_0001, 2'b00}) begin
      n_fails++;
      $display("FAIL idle_hold got=%h", got);
    end
    exHold = 1'b0;
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd2, 32'h2222_0002, 2'b00}) begin
      n_fails++;
      $display("FAIL b2b_second got=%h", got);
    end
    quiet();
    step();
  endtask

  // Starts the three-uop program at 0x040 and
  // stops right after the first uop is issued.
  task automatic start_seq3(output int errs);
    logic [36:0] got;
    errs       = 0;
    decValid   = 1'b1;
    decUopPc   = 12'h040;
    decUopWord = 32'hDEAD_BEEF;
    decStepPc  = 2'd2;
    #1;
    n_checks++;
    if (romAddr !== 12'h040) begin
      n_fails++;
      errs++;
      $display("FAIL rom_idle got=%h exp=040", romAddr);
    end
    step();
    n_checks++;
    if ({exValid, exPcStep, ifHold} !== 4'b0001) begin
      n_fails++;
      errs++;
      $display("FAIL seq_enter got=%b exp=0001",
               {exValid, exPcStep, ifHold});
    end
    quiet();
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd0, 32'hA500_0040, 2'b10}) begin
      n_fails++;
      errs++;
      $display("FAIL seq_uop1 got=%h", got);
    end
  endtask

  task automatic test_sequence();
    logic [36:0] got;
    int e;
    start_seq3(e);
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd0, 32'hA500_0041, 2'b10}) begin
      n_fails++;
      $display("FAIL seq_uop2 got=%h", got);
    end
    n_checks++;
    if (romAddr !== 12'h042) begin
      n_fails++;
      $display("FAIL rom_final got=%h exp=042", romAddr);
    end
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd2, 32'hA580_0042, 2'b00}) begin
      n_fails++;
      $display("FAIL seq_uop3 got=%h", got);
    end
    step();
    n_checks++;
    if ({exValid, exPcStep, ifHold} !== 4'b0000) begin
      n_fails++;
      $display("FAIL seq_after got=%b exp=0000",
               {exValid, exPcStep, ifHold});
    end
  endtask

  task automatic test_stall();
    logic [36:0] got;
    int e;
    start_seq3(e);
    exHold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (romAddr !== 12'h041) begin
        n_fails++;
        $display("FAIL stall_rom c=%0d got=%h exp=041",
                 c, romAddr);
      end
      step();
      got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
      n_checks++;
      if (got !== {1'b1, 2'd0, 32'hA500_0040, 2'b10}) begin
        n_fails++;
        $display("FAIL stall_hold c=%0d got=%h", c, got);
      end
    end
    exHold = 1'b0;
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd0, 32'hA500_0041, 2'b10}) begin
      n_fails++;
      $display("FAIL stall_uop2 got=%h", got);
    end
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd2, 32'hA580_0042, 2'b00}) begin
      n_fails++;
      $display("FAIL stall_uop3 got=%h", got);
    end
    step();
  endtask

  task automatic test_overrun();
    logic [36:0] got;
    logic [36:0] exp;
    decValid  = 1'b1;
    decUopPc  = 12'h100;
    decStepPc = 2'd3;
    step();
    quiet();
    for (int i = 0; i < 16; i++) begin
      step();
      exp = {1'b1,
             (i == 15) ? 2'd3 : 2'd0,
             32'hA500_0100 + 32'(i),
             (i != 15),
             (i == 15)};
      got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL overrun i=%0d got=%h exp=%h",
                 i, got, exp);
      end
    end
    step();
    n_checks++;
    if ({exValid, ifHold, seqFault} !== 3'b000) begin
      n_fails++;
      $display("FAIL overrun_end got=%b exp=000",
               {exValid, ifHold, seqFault});
    end
  endtask

  task automatic test_wrap();
    logic [36:0] got;
    decValid  = 1'b1;
    decUopPc  = 12'hFFE;
    decStepPc = 2'd1;
    step();
    quiet();
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd0, 32'hA500_0FFE, 2'b10}) begin
      n_fails++;
      $display("FAIL wrap_uop1 got=%h", got);
    end
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd1, 32'hA500_0FFF, 2'b01}) begin
      n_fails++;
      $display("FAIL wrap_uop2 got=%h", got);
    end
    step();
  endtask

  task automatic test_flush();
    logic [36:0] got;
    int e;
    start_seq3(e);
    exFlush    = 1'b1;
    exHold     = 1'b1;
    decValid   = 1'b1;
    decUopPc   = 12'd0;
    decUopWord = 32'hBAD0_BAD0;
    decStepPc  = 2'd3;
    step();
    n_checks++;
    if ({exValid, exPcStep, ifHold, seqFault} !== 5'd0) begin
      n_fails++;
      $display("FAIL flush got=%b exp=00000",
               {exValid, exPcStep, ifHold, seqFault});
    end
    exFlush    = 1'b0;
    exHold     = 1'b0;
    decUopWord = 32'h1234_5678;
    decStepPc  = 2'd2;
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd2, 32'h1234_5678, 2'b00}) begin
      n_fails++;
      $display("FAIL flush_next got=%h", got);
    end
    quiet();
    step();
  endtask

  task automatic test_reset_mid();
    logic [36:0] got;
    int e;
    start_seq3(e);
    reset      = 1'b1;
    exFlush    = 1'b1;
    decValid   = 1'b1;
    decUopPc   = 12'd0;
    decUopWord = 32'hBAD0_BAD0;
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== 37'd0) begin
      n_fails++;
      $display("FAIL reset_mid got=%h exp=0", got);
    end
    reset      = 1'b0;
    exFlush    = 1'b0;
    decUopWord = 32'h0F0F_0F0F;
    decStepPc  = 2'd1;
    step();
    got = {exValid, exPcStep, exUopWord, ifHold, seqFault};
    n_checks++;
    if (got !== {1'b1, 2'd1, 32'h0F0F_0F0F, 2'b00}) begin
      n_fails++;
      $display("FAIL reset_next got=%h", got);
    end
    quiet();
    step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 32'hA500_0000 | 32'(i);
    end
    rom[12'h042] = 32'hA580_0042;
    reset = 1'b1;
    quiet();
    test_reset();
    test_single();
    test_back_to_back();
    test_sequence();
    test_stall();
    test_overrun();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uop_seq.md
UOP_SEQ -- requirements
Module: uop_seq

Interface
REQ-001 Parameter: MAX_UOPS, default 16, the maximum number of uops one instruction may issue before a fault is forced (range 2..16).
REQ-002 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: decValid  in  1  the decoder presents a valid instruction this cycle.
REQ-005 Port: decUopPc  in  12  microcode entry from the decoder; 0 means a single uop, taken from decUopWord.
REQ-006 Port: decUopWord  in  32  direct uop word; bit 23 is END (last uop of the instruction).
REQ-007 Port: decStepPc  in  2  PC step for the instruction, in 16-bit words.
REQ-008 Port: exHold  in  1  execute stall: the sequencer neither advances nor changes its outputs.
REQ-009 Port: exFlush  in  1  abandon the current instruction or sequence (branch or exception).
REQ-010 Port: romAddr  out  12  microcode ROM read address (combinational).
REQ-011 Port: romData  in  32  synchronous ROM data, equal to uopPgm[romAddr of the previous cycle].
REQ-012 Port: exUopWord  out  32  registered uop issued to execute.
REQ-013 Port: exValid  out  1  exUopWord is valid.
REQ-014 Port: exPcStep  out  2  PC step; nonzero only on the final uop of an instruction.
REQ-015 Port: ifHold  out  1  stalls fetch and decode; equal to (state==RUN), combinational.
REQ-016 Port: seqFault  out  1  one-cycle pulse reporting a sequence overrun.

Function
REQ-017 The block SHALL implement two states, IDLE and RUN, plus a 12-bit register upc, a 4-bit register cnt and a 2-bit register savedStep.
REQ-018 romAddr SHALL equal decUopPc in IDLE; in RUN, upc+1 when advancing (RUN, !exHold, !exFlush, not final), otherwise upc.
REQ-019 Whenever exHold=1 and exFlush=0, exUopWord, exValid, exPcStep, state, upc and cnt SHALL all hold.
REQ-020 When exHold=0 and no uop is issued in a cycle, exValid SHALL be 0 at the next edge.
REQ-021 IDLE, decValid=1, exHold=0, decUopPc=0: the next edge SHALL give exUopWord=decUopWord, exValid=1, exPcStep=decStepPc, and the state SHALL stay IDLE (latency 1).
REQ-022 IDLE, decValid=1, exHold=0, decUopPc!=0: the next edge SHALL load upc=decUopPc, cnt=0, savedStep=decStepPc and enter RUN with no issue that cycle (exValid=0).
REQ-023 RUN, exHold=0: the next edge SHALL issue exUopWord=romData with exValid=1.
REQ-024 On the RUN issue of REQ-023, the uop is final if romData[23]=1, cnt=MAX_UOPS-1, or upc=12'hFFF.
REQ-025 On a final RUN issue: exPcStep=savedStep and state returns to IDLE.
REQ-026 On a non-final RUN issue: exPcStep=0, upc=upc+1, cnt=cnt+1.
REQ-027 A final uop forced by cnt or upc wrap (romData[23]=0) SHALL still be issued, and seqFault SHALL be 1 for exactly the cycle in which that uop is valid.
REQ-028 decValid SHALL be ignored in RUN; the decoder holds its output while ifHold=1.
REQ-029 exFlush=1 SHALL take priority over exHold and over decValid: the next edge gives state=IDLE, exValid=0, exPcStep=0, seqFault=0, and that cycle's decoder input is discarded.
REQ-030 At most one uop SHALL be issued per cycle; in RUN, back-to-back uops issue on consecutive cycles when exHold=0.

Reset
REQ-031 On reset=1 at a clock edge, including mid-sequence, the block SHALL set state=IDLE, upc=0, cnt=0, savedStep=0, exUopWord=0, exValid=0, exPcStep=0 and seqFault=0, so ifHold=0.
REQ-032 Reset SHALL take priority over exFlush, exHold and decValid.

Verification
REQ-033 Single uop: IDLE, decValid=1, decUopPc=0, decUopWord=32'h1F80_0000, decStepPc=1 -> next cycle exValid=1, exUopWord=32'h1F80_0000, exPcStep=1.
REQ-034 Three-uop sequence: decUopPc=12'h040; ROM words at 40 and 41 have bit23=0, the word at 42 has bit23=1; decStepPc=2 -> exValid=0 for one cycle, then three consecutive uops; exPcStep=0,0,2; ifHold high until the third uop is issued.
REQ-035 Stall: exHold=1 for 3 cycles during the second uop of REQ-034 -> outputs frozen; romAddr stays 12'h041; the sequence completes unchanged after release.
REQ-036 Overrun: MAX_UOPS=16 and a ROM with no END bit -> 16 uops issued; seqFault pulses with the 16th; exPcStep=savedStep; state returns to IDLE.
REQ-037 Address wrap: decUopPc=12'hFFE with no END bit -> 2 uops issued; the second carries seqFault=1.
REQ-038 Flush or reset mid-sequence: exFlush=1, or reset=1, during the second uop of REQ-034 -> next cycle exValid=0 and ifHold=0; a new decUopPc=0 instruction then issues normally.
